// File: rtl/uart_rx_top.sv
// uart_rx_top: 8N1 serial receiver with a one-entry holding register.
// rx_in is synchronised, sampled mid-bit, deserialised LSB first and
// committed to data_out/valid. Framing and overrun errors are 1-cycle pulses.
// Optional even-parity support is enabled by defining UART_RX_PARITY_EN;
// without it the frame is 8N1 and parity_err is tied low.
module uart_rx_top #(
    parameter int CLKS_PER_BIT = 868,
    parameter int DATA_BITS    = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx_in,
    input  logic                 read_en,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 valid,
    output logic                 busy,
    output logic                 framing_err,
    output logic                 overrun_err,
    output logic                 parity_err
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = $clog2(DATA_BITS + 1);

    localparam logic [CNT_W-1:0] HALF_M1  = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_M1  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t state;
    state_t state_next;

    // Synchroniser chain: rx_meta/rx_s form the 2-flop synchroniser, rx_d
    // delays rx_s by one more cycle for falling-edge detection.
    logic rx_meta;
    logic rx_s;
    logic rx_d;

    logic [CNT_W-1:0]     bit_cnt;
    logic [IDX_W-1:0]     idx;
    logic [DATA_BITS-1:0] shreg;

    logic start_tick;
    logic data_tick;
    logic stop_tick;
    logic cnt_clr;
    logic par_fail;
    logic frame_ok;
    logic take;

`ifdef UART_RX_PARITY_EN
    logic par_tick;

    // Even parity: the data bits together with the parity bit must XOR to 0.
    function automatic logic parity_bad(input logic [DATA_BITS-1:0] d, input logic p);
        return ^{d, p};
    endfunction
`endif

    // Bring the asynchronous line into the clk domain; idle-high after reset
    // so a reset never looks like a start edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            rx_d    <= 1'b1;
        end else begin
            rx_meta <= rx_in;
            rx_s    <= rx_meta;
            rx_d    <= rx_s;
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FSM next-state logic. A low line after returning to IDLE has rx_d=0,
    // so only a genuine high-to-low transition starts a new frame.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (rx_d && !rx_s) begin
                    state_next = S_START;
                end
            end
            S_START: begin
                if (start_tick) begin
                    state_next = rx_s ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (data_tick && (idx == LAST_IDX)) begin
`ifdef UART_RX_PARITY_EN
                    state_next = S_PARITY;
`else
                    state_next = S_STOP;
`endif
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (par_tick) begin
                    state_next = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (stop_tick) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // FSM outputs: busy flag, per-state sample strobes and commit decision.
    always_comb begin
        busy       = (state != S_IDLE);
        start_tick = (state == S_START) && (bit_cnt == HALF_M1);
        data_tick  = (state == S_DATA)  && (bit_cnt == FULL_M1);
        stop_tick  = (state == S_STOP)  && (bit_cnt == FULL_M1);
`ifdef UART_RX_PARITY_EN
        par_tick   = (state == S_PARITY) && (bit_cnt == FULL_M1);
        cnt_clr    = (state == S_IDLE) || start_tick || data_tick || par_tick || stop_tick;
`else
        cnt_clr    = (state == S_IDLE) || start_tick || data_tick || stop_tick;
`endif
        frame_ok   = stop_tick && rx_s && !par_fail;
        take       = frame_ok && (!valid || read_en);
    end

    // Bit-period counter restarts on every sample point; idx counts data bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt <= '0;
            idx     <= '0;
        end else begin
            if (cnt_clr) begin
                bit_cnt <= '0;
            end else begin
                bit_cnt <= bit_cnt + CNT_ONE;
            end
            if (state != S_DATA) begin
                idx <= '0;
            end else if (data_tick) begin
                idx <= idx + IDX_ONE;
            end
        end
    end

    // Shift register fills from the MSB so the first (LSB) bit ends at bit 0.
    always_ff @(posedge clk) begin
        if (data_tick) begin
            shreg <= {rx_s, shreg[DATA_BITS-1:1]};
        end
    end

`ifdef UART_RX_PARITY_EN
    // Parity verdict is held until the stop sample so both checks report together.
    always_ff @(posedge clk) begin
        if (rst) begin
            par_fail <= 1'b0;
        end else if (par_tick) begin
            par_fail <= parity_bad(shreg, rx_s);
        end
    end
`else
    assign par_fail = 1'b0;
`endif

    // Holding register, consumer pop and single-cycle error pulses. A commit
    // coinciding with read_en replaces the byte and keeps valid high.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_out    <= '0;
            valid       <= 1'b0;
            framing_err <= 1'b0;
            overrun_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err  <= 1'b0;
`endif
        end else begin
            framing_err <= stop_tick && !rx_s;
            overrun_err <= frame_ok && valid && !read_en;
`ifdef UART_RX_PARITY_EN
            parity_err  <= stop_tick && par_fail;
`endif
            if (take) begin
                data_out <= shreg;
                valid    <= 1'b1;
            end else if (valid && read_en) begin
                valid <= 1'b0;
            end
        end
    end

`ifndef UART_RX_PARITY_EN
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_top.sv
// Testbench for uart_rx_top with CLKS_PER_BIT=16: directed scenarios with
// literal expectations, then randomized frames and read_en checked every
// cycle against a frame-level model.
module tb_uart_rx_top;

    localparam int CPB = 16;
    localparam int DB  = 8;
`ifdef UART_RX_PARITY_EN
    localparam int NPAR = 1;
`else
    localparam int NPAR = 0;
`endif
    // Cycles from the first clk edge that samples the start bit low to the
    // edge where the frame outcome becomes visible.
    localparam int LAT = 2 + CPB / 2 + (DB + 1) * CPB + NPAR * CPB;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          rx_in = 1'b1;
    logic          read_en = 1'b0;
    logic [DB-1:0] data_out;
    logic          valid;
    logic          busy;
    logic          framing_err;
    logic          overrun_err;
    logic          parity_err;

    uart_rx_top #(.CLKS_PER_BIT(CPB), .DATA_BITS(DB)) dut (
        .clk        (clk),
        .rst        (rst),
        .rx_in      (rx_in),
        .read_en    (read_en),
        .data_out   (data_out),
        .valid      (valid),
        .busy       (busy),
        .framing_err(framing_err),
        .overrun_err(overrun_err),
        .parity_err (parity_err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    bit chk_en = 0;
    bit rnd_done = 0;

    // Frame-level model state
    bit          m_valid = 0;
    logic [7:0]  m_data = 8'h00;
    bit          e_ferr = 0, e_oerr = 0, e_perr = 0;
    int          busy_from = 0, busy_to = 0;
    bit          fr_pend = 0;
    int          fr_done = 0;
    logic [7:0]  fr_byte = 8'h00;
    bit          fr_stop = 1, fr_parok = 1;
    int          cur_F = -1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
        end
    endtask

    // Model: advances once per clock edge using the outcome of any frame
    // whose result is due on this edge.
    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            e_ferr = 0;
            e_oerr = 0;
            e_perr = 0;
            if (rst) begin
                m_valid = 0;
                m_data  = 8'h00;
                fr_pend = 0;
                if (busy_to > cyc) busy_to = cyc;
            end else if (fr_pend && cyc == fr_done) begin
                fr_pend = 0;
                if (fr_stop && fr_parok) begin
                    if (!m_valid || read_en) begin
                        m_data  = fr_byte;
                        m_valid = 1;
                    end else begin
                        e_oerr = 1;
                    end
                end else begin
                    e_ferr = !fr_stop;
                    e_perr = !fr_parok;
                    if (m_valid && read_en) m_valid = 0;
                end
            end else if (m_valid && read_en) begin
                m_valid = 0;
            end
        end
    end

    // Every-cycle comparison of the DUT against the model.
    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                chk("valid", valid, m_valid);
                chk("data_out", data_out, m_data);
                chk("busy", busy, (cyc >= busy_from && cyc < busy_to));
                chk("framing_err", framing_err, e_ferr);
                chk("overrun_err", overrun_err, e_oerr);
                chk("parity_err", parity_err, e_perr);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL timeout at cycle %0d", cyc);
        $fatal(1, "timeout");
    end

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic hold();
        repeat (CPB) @(posedge clk);
        #1;
    endtask

    task automatic gap(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] b, input bit stop, input bit par_good);
        @(posedge clk);
        #1;
        rx_in     = 1'b0;
        fr_byte   = b;
        fr_stop   = stop;
        fr_parok  = (NPAR == 0) ? 1'b1 : par_good;
        fr_done   = cyc + 1 + LAT;
        busy_from = cyc + 3;
        busy_to   = cyc + 1 + LAT;
        fr_pend   = 1;
        cur_F     = cyc + 1;
        hold();
        for (int k = 0; k < DB; k++) begin
            rx_in = b[k];
            hold();
        end
`ifdef UART_RX_PARITY_EN
        rx_in = (^b) ^ !par_good;
        hold();
`endif
        rx_in = stop;
        hold();
        rx_in = 1'b1;
    endtask

    task automatic glitch(input int n, input bit probe_it);
        int f;
        @(posedge clk);
        #1;
        rx_in     = 1'b0;
        f         = cyc + 1;
        busy_from = f + 2;
        busy_to   = f + 2 + CPB / 2;
        repeat (n) @(posedge clk);
        #1;
        rx_in = 1'b1;
        if (probe_it) begin
            wait_until(f + 3);
            chk("glitch.busy_high", busy, 1);
            wait_until(f + 2 + CPB / 2);
            chk("glitch.busy_low", busy, 0);
            chk("glitch.valid", valid, 0);
            chk("glitch.framing_err", framing_err, 0);
        end
        gap(CPB);
    endtask

    // Literal checks around the outcome edge of the frame being sent.
    task automatic probe(input string nm, input bit pre_valid, input bit exp_valid,
                         input logic [7:0] exp_data, input bit exp_ferr,
                         input bit exp_oerr, input bit exp_perr);
        int f;
        while (cur_F < 0) @(negedge clk);
        f = cur_F;
        wait_until(f + LAT - 1);
        chk({nm, ".pre_valid"}, valid, pre_valid);
        chk({nm, ".pre_busy"}, busy, 1);
        wait_until(f + LAT);
        chk({nm, ".valid"}, valid, exp_valid);
        chk({nm, ".data_out"}, data_out, exp_data);
        chk({nm, ".framing_err"}, framing_err, exp_ferr);
        chk({nm, ".overrun_err"}, overrun_err, exp_oerr);
        chk({nm, ".parity_err"}, parity_err, exp_perr);
        chk({nm, ".busy"}, busy, 0);
        wait_until(f + LAT + 1);
        chk({nm, ".pulse_end"}, {framing_err, overrun_err, parity_err}, 0);
    endtask

    task automatic pop(input string nm, input logic [7:0] exp_data);
        @(posedge clk);
        #1;
        read_en = 1'b1;
        @(posedge clk);
        #1;
        read_en = 1'b0;
        @(negedge clk);
        chk({nm, ".pop_valid"}, valid, 0);
        chk({nm, ".pop_data"}, data_out, exp_data);
    endtask

    task automatic sent(input string nm, input logic [7:0] b, input bit stop, input bit pg,
                        input bit pre_v, input bit exp_v, input logic [7:0] exp_d,
                        input bit ef, input bit eo, input bit ep);
        cur_F = -1;
        fork
            send_frame(b, stop, pg);
            probe(nm, pre_v, exp_v, exp_d, ef, eo, ep);
        join
        gap(3);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk_en = 1;
        chk("reset.valid", valid, 0);
        chk("reset.data_out", data_out, 0);
        chk("reset.busy", busy, 0);
        chk("reset.errs", {framing_err, overrun_err, parity_err}, 0);
        gap(5);

        // Good frame, then a single-cycle pop
        sent("t1", 8'hA5, 1, 1, 0, 1, 8'hA5, 0, 0, 0);
        pop("t1", 8'hA5);

        // False start
        glitch(4, 1);

        // Framing error, then a good frame
        sent("t3a", 8'h3C, 0, 1, 0, 0, 8'hA5, 1, 0, 0);
        sent("t3b", 8'h11, 1, 1, 0, 1, 8'h11, 0, 0, 0);
        pop("t3", 8'h11);

        // Overrun: second byte dropped
        sent("t4a", 8'h01, 1, 1, 0, 1, 8'h01, 0, 0, 0);
        sent("t4b", 8'h02, 1, 1, 1, 1, 8'h01, 0, 1, 0);
        pop("t4", 8'h01);

        // Reset in the middle of DATA
        cur_F = -1;
        fork
            send_frame(8'hFF, 1, 1);
            begin
                while (cur_F < 0) @(negedge clk);
                wait_until(cur_F + 2 + CPB / 2 + 3 * CPB + 5);
                rst = 1'b1;
                @(posedge clk);
                @(posedge clk);
                #1;
                rst = 1'b0;
                @(negedge clk);
                chk("t5.valid", valid, 0);
                chk("t5.data_out", data_out, 0);
                chk("t5.busy", busy, 0);
            end
        join
        gap(5);
        sent("t5b", 8'h5A, 1, 1, 0, 1, 8'h5A, 0, 0, 0);
        pop("t5", 8'h5A);

`ifdef UART_RX_PARITY_EN
        sent("t6a", 8'h07, 1, 0, 0, 0, 8'h5A, 0, 0, 1);
        sent("t6b", 8'h07, 1, 1, 0, 1, 8'h07, 0, 0, 0);
        pop("t6", 8'h07);
`endif

        // Randomized frames with concurrent random read_en
        fork
            begin
                while (!rnd_done) begin
                    @(posedge clk);
                    #1;
                    read_en = ($urandom_range(0, 5) == 0);
                end
                read_en = 1'b0;
            end
            begin
                for (int it = 0; it < 30; it++) begin
                    if ($urandom_range(0, 9) == 0) begin
                        glitch($urandom_range(1, 6), 0);
                    end else begin
                        send_frame(8'($urandom), $urandom_range(0, 4) != 0,
                                   $urandom_range(0, 3) != 0);
                    end
                    gap($urandom_range(3, 20));
                end
                rnd_done = 1;
            end
        join
        gap(5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
